// File: rtl/sgdmac_pkg.sv
// Shared constants and types for the scatter-gather DMA engines.
package sgdmac_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES     = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/sgdmac_wr_engine_if.sv
// AXI write channels plus the FWFT read-side FIFO port of the write engine.
interface sgdmac_wr_engine_if #(parameter int DATA_W = 32);
  localparam int BYTES = DATA_W / 8;

  logic [31:0]       awaddr_o;
  logic [3:0]        awlen_o;
  logic [2:0]        awsize_o;
  logic [1:0]        awburst_o;
  logic              awvalid_o;
  logic              awready_i;
  logic [3:0]        wid_o;
  logic [DATA_W-1:0] wdata_o;
  logic [BYTES-1:0]  wstrb_o;
  logic              wlast_o;
  logic              wvalid_o;
  logic              wready_i;
  logic [1:0]        bresp_i;
  logic              bvalid_i;
  logic              bready_o;
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_rdata_i;
  logic              fifo_rden_o;

  modport master (
    output awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
    output bready_o, fifo_rden_o,
    input  awready_i, wready_i, bresp_i, bvalid_i, fifo_empty_i, fifo_rdata_i
  );

  modport slave (
    input  awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
    input  bready_o, fifo_rden_o,
    output awready_i, wready_i, bresp_i, bvalid_i, fifo_empty_i, fifo_rdata_i
  );
endinterface

// File: rtl/sgdmac_len_fifo.sv
// Small synchronous FIFO of burst lengths linking AW issue to W streaming.
module sgdmac_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/sgdmac_wr_engine.sv
// AXI write engine: splits one command into 4 KB-safe INCR bursts, AW runs ahead of W.
module sgdmac_wr_engine
  import sgdmac_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LEN_W-1:0]    byte_len_i,
  output logic                done_o,
  output logic                err_o,
  sgdmac_wr_engine_if.master  bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int BEAT_W = LEN_W + 1;
  localparam int CW     = (BEAT_W > 13) ? BEAT_W : 13;
  localparam int OS_W   = $clog2(MAX_OUTSTANDING + 1);

  state_t            state, state_nxt;
  logic [31:0]       addr;
  logic [BEAT_W-1:0] aw_left, w_left, w_left_nxt, total_beats;
  logic [OFF_W-1:0]  tail;
  logic [OS_W-1:0]   os_cnt, os_nxt;
  logic [3:0]        w_idx;
  logic              err;

  logic [CW-1:0]     to_4k, burst_beats;
  logic [31:0]       burst_bytes;
  logic [3:0]        awlen, q_head;
  logic              q_empty, q_full;
  logic              aw_ok, aw_hs, w_ok, w_last, w_hs, b_hs;
  logic [BYTES-1:0]  strb_tail, strb;

  assign total_beats = (BEAT_W'(byte_len_i) + BEAT_W'(BYTES - 1)) >> OFF_W;

  // Burst size is the smallest of the AXI3 limit, what is left, and the room to the page end.
  assign to_4k = (CW'(PAGE_BYTES) - CW'(addr[11:0])) >> OFF_W;
  always_comb begin
    burst_beats = CW'(MAX_BURST);
    if (CW'(aw_left) < burst_beats) burst_beats = CW'(aw_left);
    if (to_4k < burst_beats)        burst_beats = to_4k;
  end
  assign burst_bytes = 32'(burst_beats) << OFF_W;
  assign awlen       = (aw_left != '0) ? 4'(burst_beats - CW'(1)) : 4'd0;

  assign aw_ok  = (state == RUN) && (aw_left != '0) &&
                  (os_cnt < OS_W'(MAX_OUTSTANDING)) && !q_full;
  assign aw_hs  = aw_ok && bus.awready_i;
  assign w_ok   = !q_empty && !bus.fifo_empty_i;
  assign w_last = !q_empty && (w_idx == q_head);
  assign w_hs   = w_ok && bus.wready_i;
  assign b_hs   = bus.bvalid_i && (os_cnt != '0);

  always_comb begin
    strb_tail = '0;
    for (int i = 0; i < BYTES; i++) strb_tail[i] = (i < int'(tail));
  end
  assign strb = ((w_left == BEAT_W'(1)) && (tail != '0)) ? strb_tail : '1;

  always_comb begin
    os_nxt = os_cnt;
    if (aw_hs && !b_hs)      os_nxt = os_cnt + OS_W'(1);
    else if (!aw_hs && b_hs) os_nxt = os_cnt - OS_W'(1);
  end
  assign w_left_nxt = w_hs ? w_left - BEAT_W'(1) : w_left;

  sgdmac_len_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(4)) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (aw_hs),
    .din   (awlen),
    .pop   (w_hs && w_last),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DRAIN looks at next-cycle counts so done rises right after the final B.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && (byte_len_i != '0)) state_nxt = RUN;
      RUN:     if (aw_left == '0) state_nxt = DRAIN;
      DRAIN:   if ((os_nxt == '0) && (w_left_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr    <= '0;
      aw_left <= '0;
      w_left  <= '0;
      tail    <= '0;
      os_cnt  <= '0;
      w_idx   <= '0;
      err     <= 1'b0;
    end else if (state == IDLE && start_i) begin
      err     <= 1'b0;
      addr    <= dst_addr_i;
      aw_left <= total_beats;
      w_left  <= total_beats;
      tail    <= byte_len_i[OFF_W-1:0];
    end else begin
      if (aw_hs) begin
        addr    <= addr + burst_bytes;
        aw_left <= aw_left - BEAT_W'(burst_beats);
      end
      if (w_hs) w_idx <= w_last ? 4'd0 : w_idx + 4'd1;
      w_left <= w_left_nxt;
      os_cnt <= os_nxt;
      if (b_hs && (bus.bresp_i != AXI_RESP_OKAY)) err <= 1'b1;
    end
  end

  assign done_o          = (state == IDLE);
  assign err_o           = err;
  assign bus.awaddr_o    = addr;
  assign bus.awlen_o     = awlen;
  assign bus.awsize_o    = 3'(OFF_W);
  assign bus.awburst_o   = AXI_BURST_INCR;
  assign bus.awvalid_o   = aw_ok;
  assign bus.wid_o       = 4'd0;
  assign bus.wdata_o     = bus.fifo_rdata_i;
  assign bus.wstrb_o     = w_ok ? strb : '0;
  assign bus.wlast_o     = w_last;
  assign bus.wvalid_o    = w_ok;
  assign bus.bready_o    = (os_cnt != '0);
  assign bus.fifo_rden_o = w_hs;
endmodule
